// File: rtl/bin_to_bcd4.sv
// bin_to_bcd4
// Sequential 14-bit binary to 4-digit BCD converter using the shift-and-add-3
// (double-dabble) method, one bit per clock.
// Inputs above 9999 saturate to 9999 and raise ovf with the result.
//
// Ports
//   clk       system clock, all state updates on the rising edge
//   rst       synchronous active-high reset
//   start     conversion request, only honoured while idle
//   bin       14-bit unsigned value, captured on the edge that accepts start
//   busy      high while a conversion is running
//   done      one-cycle pulse when new digits appear
//   ovf       last accepted value exceeded 9999
//   dig_thou  BCD thousands digit
//   dig_hund  BCD hundreds digit
//   dig_ten   BCD tens digit
//   dig_one   BCD ones digit
module bin_to_bcd4 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [3:0]  dig_thou,
    output logic [3:0]  dig_hund,
    output logic [3:0]  dig_ten,
    output logic [3:0]  dig_one
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state_reg;
    logic [15:0] scratch_reg;
    logic [13:0] operand_reg;
    logic [3:0]  count_reg;
    logic        ovf_pending_reg;

    // Add-3 correction applied to every BCD nibble before the shift.
    logic [15:0] adjusted;
    // {scratch, operand} after the one-bit left shift; the operand MSB
    // lands in the scratch LSB.
    logic [29:0] shifted;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adjust
            assign adjusted[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5)
                                       ? scratch_reg[gi*4 +: 4] + 4'd3
                                       : scratch_reg[gi*4 +: 4];
        end
    endgenerate

    assign shifted = {adjusted, operand_reg} << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            ovf             <= 1'b0;
            dig_thou        <= 4'd0;
            dig_hund        <= 4'd0;
            dig_ten         <= 4'd0;
            dig_one         <= 4'd0;
            scratch_reg     <= 16'd0;
            operand_reg     <= 14'd0;
            count_reg       <= 4'd0;
            ovf_pending_reg <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        // Saturate so the four digits always hold legal BCD.
                        if (bin > 14'd9999) begin
                            operand_reg     <= 14'd9999;
                            ovf_pending_reg <= 1'b1;
                        end else begin
                            operand_reg     <= bin;
                            ovf_pending_reg <= 1'b0;
                        end
                        scratch_reg <= 16'd0;
                        count_reg   <= 4'd0;
                        busy        <= 1'b1;
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_reg <= shifted[29:14];
                    operand_reg <= shifted[13:0];
                    count_reg   <= count_reg + 4'd1;
                    if (count_reg == 4'd13) begin
                        state_reg <= FINISH;
                    end
                end
                FINISH: begin
                    dig_thou  <= scratch_reg[15:12];
                    dig_hund  <= scratch_reg[11:8];
                    dig_ten   <= scratch_reg[7:4];
                    dig_one   <= scratch_reg[3:0];
                    ovf       <= ovf_pending_reg;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd4.sv
// tb_bin_to_bcd4
// Self-checking bench for bin_to_bcd4: directed values, an ignored mid-run
// start, a mid-run reset, random single conversions and a back-to-back run
// with start held high. Expected digits come from decimal arithmetic on the
// saturated input value.
module tb_bin_to_bcd4;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [3:0]  dig_thou;
    logic [3:0]  dig_hund;
    logic [3:0]  dig_ten;
    logic [3:0]  dig_one;

    int n_checks = 0;
    int n_fail   = 0;

    bin_to_bcd4 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .dig_thou (dig_thou),
        .dig_hund (dig_hund),
        .dig_ten  (dig_ten),
        .dig_one  (dig_one)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Decimal reference: saturate, then split into digits arithmetically.
    function automatic logic [15:0] ref_digits(input int value);
        int s;
        s = (value > 9999) ? 9999 : value;
        ref_digits = {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic [15:0] observed_digits();
        observed_digits = {dig_thou, dig_hund, dig_ten, dig_one};
    endfunction

    // One conversion. inj_at >= 0 pulses start (bin=7) after that many cycles;
    // rst_at >= 0 asserts reset after that many cycles and expects an abort.
    task automatic run_conv(input int value, input int inj_at, input int rst_at);
        int          cycles;
        int          dones;
        logic [16:0] prev;
        logic [15:0] exp_d;
        logic        exp_ovf;
        exp_d   = ref_digits(value);
        exp_ovf = (value > 9999);
        prev    = {ovf, observed_digits()};
        bin   = value[13:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bin   = 14'($urandom);
        check("busy_after_accept", busy, 1);
        cycles = 0;
        while (!done && cycles < 40) begin
            if (cycles == inj_at) begin
                start = 1'b1;
                bin   = 14'd7;
            end
            if (cycles == rst_at) rst = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cycles++;
            if (rst) begin
                rst = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_digits", observed_digits(), 16'h0000);
                check("abort_ovf", ovf, 0);
                dones = 0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (done) dones++;
                end
                check("abort_no_done", dones, 0);
                $display("conv %0d aborted by reset after %0d cycles", value, cycles);
                return;
            end
            if (cycles == 7) check("hold_during_conv", {ovf, observed_digits()}, prev);
            if (cycles == 14) check("busy_last_shift", busy, 1);
        end
        check("latency", cycles, 15);
        check("busy_at_done", busy, 0);
        check("digits", observed_digits(), exp_d);
        check("ovf", ovf, exp_ovf);
        @(negedge clk);
        check("done_single_pulse", done, 0);
        $display("conv %0d -> %h ovf=%0b latency=%0d", value, observed_digits(), ovf, cycles);
    endtask

    initial begin
        int          cycles;
        int          vals[$];
        int          v;
        rst   = 1'b1;
        start = 1'b1;
        bin   = 14'd1234;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ovf", ovf, 0);
        check("reset_digits", observed_digits(), 16'h0000);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        run_conv(0, -1, -1);
        run_conv(1234, -1, -1);
        run_conv(9999, -1, -1);
        run_conv(10, -1, -1);
        run_conv(16383, -1, -1);
        run_conv(5, -1, -1);
        run_conv(10000, -1, -1);
        run_conv(4321, 5, -1);
        run_conv(8765, -1, 8);
        run_conv(2468, -1, -1);
        for (int i = 0; i < 6; i++) run_conv(int'($urandom_range(0, 16383)), -1, -1);

        // Back-to-back with start held high: one result every 16 cycles.
        for (int i = 0; i < 8; i++) vals.push_back(int'($urandom_range(0, 9999)));
        bin   = vals[0][13:0];
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            cycles = 0;
            while (!done && cycles < 40) begin
                @(negedge clk);
                cycles++;
            end
            v = vals[i];
            check("b2b_period", cycles, 15);
            check("b2b_digits", observed_digits(), ref_digits(v));
            check("b2b_ovf", ovf, 0);
            $display("b2b conv %0d -> %h after %0d cycles", v, observed_digits(), cycles);
            if (i < 7) bin = vals[i + 1][13:0];
            else start = 1'b0;
            @(negedge clk);
            check("b2b_done_clear", done, 0);
            if (i < 7) check("b2b_busy_reaccept", busy, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
